// File: rtl/sseg_pkg.sv
// Shared definitions for the signed seven-segment display controller.
//   DIGIT_MINUS / DIGIT_BLANK : non-numeric position codes (0-9 are digits)
//   NUM_POS                   : number of display positions
//   state_t                   : conversion FSM encoding
package sseg_pkg;

    localparam int NUM_POS = 4;

    typedef logic [3:0] code_t;

    localparam code_t DIGIT_MINUS = 4'hA;
    localparam code_t DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/sseg_code_decode.sv
// Combinational decode of a 4-bit position code to a 7-segment pattern.
//   code    : 0-9 digit, 0xA minus, anything else blank
//   seg_pat : active-high segments, bit 0 = a ... bit 6 = g
module sseg_code_decode
    import sseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_pat
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        seg_pat = 7'b000_0000;
        case (code)
            4'd0:        seg_pat = 7'h3F;
            4'd1:        seg_pat = 7'h06;
            4'd2:        seg_pat = 7'h5B;
            4'd3:        seg_pat = 7'h4F;
            4'd4:        seg_pat = 7'h66;
            4'd5:        seg_pat = 7'h6D;
            4'd6:        seg_pat = 7'h7D;
            4'd7:        seg_pat = 7'h07;
            4'd8:        seg_pat = 7'h7F;
            4'd9:        seg_pat = 7'h6F;
            DIGIT_MINUS: seg_pat = 7'h40;
            default:     seg_pat = 7'h00;
        endcase
    end

endmodule

// File: rtl/signed_display_ctrl.sv
// Converts an 8-bit two's-complement value into sign + decimal digit codes
// and scans them onto a 4-position multiplexed 7-segment display.
//   clk, rst_n : system clock, asynchronous active-low reset
//   load       : convert and display value (ignored while busy)
//   value      : signed input, -128..127
//   busy       : conversion in progress (CONVERT or COMMIT)
//   done       : one-cycle pulse when the new digits reach the display
//   an         : one-hot digit enable, bit 0 = ones position
//   segs       : active-high segments a..g (bit 0 = a) for the lit position
module signed_display_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] segs
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t      state, state_nxt;
    logic [8:0]  quot;
    logic [8:0]  quot_div10;
    code_t       digit;
    logic        neg;
    logic [1:0]  wpos;
    logic [1:0]  wpos_nxt;
    code_t       work [NUM_POS];
    code_t       disp [NUM_POS];

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       idx;
    logic [6:0]       seg_pat;

    assign quot_div10 = quot / 9'd10;
    assign digit      = 4'(quot % 9'd10);
    assign wpos_nxt   = wpos + 2'd1;
    assign busy       = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONVERT;
            CONVERT: if (quot_div10 == 9'd0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- conversion datapath ----------------
    // Digits build up in work[]; disp[] only changes in COMMIT, so a
    // partially converted number is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot <= 9'd0;
            neg  <= 1'b0;
            wpos <= 2'd0;
            done <= 1'b0;
            // NOTE: these register arrays are tiny and must power up to a defined "0" display, so they are reset like any flop.
            for (int i = 0; i < NUM_POS; i++) begin
                work[i] <= DIGIT_BLANK;
                disp[i] <= DIGIT_BLANK;
            end
            disp[0] <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        // 9-bit magnitude so -128 becomes +128.
                        quot <= value[7] ? (9'd256 - {1'b0, value}) : {1'b0, value};
                        neg  <= value[7];
                        wpos <= 2'd0;
                        for (int i = 0; i < NUM_POS; i++) work[i] <= DIGIT_BLANK;
                    end
                end
                CONVERT: begin
                    work[wpos] <= digit;
                    quot       <= quot_div10;
                    wpos       <= wpos_nxt;
                    // Last digit this cycle: the sign goes just left of it.
                    if (quot_div10 == 9'd0 && neg) work[wpos_nxt] <= DIGIT_MINUS;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_POS; i++) disp[i] <= work[i];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- display scan ----------------
    sseg_code_decode u_decode (
        .code    (disp[idx]),
        .seg_pat (seg_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an       <= 4'b0001;
            segs     <= 7'h3F;
        end else begin
            if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            // Registered outputs trail the index by one cycle.
            an   <= 4'b0001 << idx;
            segs <= seg_pat;
        end
    end

endmodule

// File: tb/tb_signed_display_ctrl.sv
module tb_signed_display_ctrl;

    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] segs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;

    typedef struct {
        logic [15:0] codes;   // {pos3,pos2,pos1,pos0}
        int          lat;     // cycles from sampling edge to done
        int          edge_no; // cyc value of the sampling edge
        bit          chk_disp;
    } exp_t;

    exp_t sb[$];

    signed_display_ctrl #(.REFRESH_DIV(RDIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .an    (an),
        .segs  (segs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_count <= done_count + 1;

    function automatic logic [6:0] pat(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  4'hA: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Watch 16 scan samples (covers every position) and compare segs
    // with the pattern expected for whichever position is lit.
    task automatic observe_display(input string tag, input logic [15:0] codes);
        int p;
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b0001: p = 0;
                4'b0010: p = 1;
                4'b0100: p = 2;
                4'b1000: p = 3;
                default: p = -1;
            endcase
            check({tag, "_an_onehot"}, {31'd0, (p >= 0)}, 32'd1);
            if (p >= 0) check({tag, "_segs"}, {25'd0, segs}, {25'd0, pat(codes[p*4 +: 4])});
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin : monitor
        exp_t e;
        int   busy_run;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                busy_run = 0;
            end else if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - e.edge_no, e.lat);
                    check("busy_cycles", busy_run, e.lat);
                    check("busy_low_at_done", {31'd0, busy}, 32'd0);
                    if (e.chk_disp) observe_display("disp", e.codes);
                end
                busy_run = 0;
            end else if (busy === 1'b1) begin
                busy_run++;
            end
        end
    end

    // Called at a negedge: drives load for one cycle and records the expectation.
    task automatic issue(input logic [7:0] v, input logic [15:0] codes, input int lat, input bit chk);
        exp_t e;
        e.codes    = codes;
        e.lat      = lat;
        e.edge_no  = cyc + 1;
        e.chk_disp = chk;
        load  = 1'b1;
        value = v;
        sb.push_back(e);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin : driver
        int c0;
        logic [3:0] exp_an;
        rst_n = 1'b0;
        load  = 1'b0;
        value = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_an", {28'd0, an}, 32'h1);
        check("reset_segs", {25'd0, segs}, 32'h3F);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // Scan: each position lit RDIV cycles, outputs one cycle behind the index.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_an = 4'b0001 << (((k - 1) / RDIV) % 4);
            check("scan_an", {28'd0, an}, {28'd0, exp_an});
            check("scan_segs", {25'd0, segs}, (exp_an == 4'b0001) ? 32'h3F : 32'h00);
        end

        issue(8'h00, 16'hFFF0, 2, 1'b1); wait_done("zero");      repeat (20) @(negedge clk);
        issue(8'hFB, 16'hFFA5, 2, 1'b1); wait_done("minus5");    repeat (20) @(negedge clk);
        issue(8'h80, 16'hA128, 4, 1'b1); wait_done("minus128");  repeat (20) @(negedge clk);
        issue(8'h2D, 16'hFF45, 3, 1'b1); wait_done("p45");       repeat (20) @(negedge clk);

        // 127, with load held high (value 1) through every busy cycle.
        issue(8'h7F, 16'hF127, 4, 1'b1);
        load  = 1'b1;
        value = 8'h01;
        repeat (4) @(negedge clk);
        load  = 1'b0;
        wait_done("p127");
        @(negedge clk);
        c0 = done_count;
        repeat (20) @(negedge clk);
        check("ignored_load_no_done", done_count - c0, 32'd0);

        // Back-to-back: second load in the cycle done is high.
        issue(8'h09, 16'hFFF9, 2, 1'b0); wait_done("b2b_first");
        issue(8'h9D, 16'hFA99, 3, 1'b1); wait_done("b2b_second");
        repeat (20) @(negedge clk);

        // Reset in the middle of converting 100.
        load  = 1'b1;
        value = 8'h64;
        @(negedge clk);
        load  = 1'b0;
        @(negedge clk);
        c0 = done_count;
        rst_n = 1'b0;
        #1;
        check("midreset_an", {28'd0, an}, 32'h1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_segs", {25'd0, segs}, 32'h3F);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_no_done", done_count - c0, 32'd0);
        observe_display("after_reset", 16'hFFF0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
